stage_mo: RTL and testbench
===========================

# stage_mo

Memory Operation (MO) pipeline stage of the 12-bit core. It accepts one instruction per cycle from the upstream latch and performs at most one data-memory access per instruction over a req/ack port. It stalls upstream while an access is outstanding. It presents the instruction, instruction set, PC and result to the MO/RA latch, and its `done_out` drives that latch's `enable`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 15: max cycles in REQ before abort; used only with `MO_TIMEOUT_EN`; range 1–15.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `valid_in` in 1: upstream instruction valid; 0 means bubble.
- `instr_in` in 12: instruction word.
- `instr_set_in` in 4: active instruction set.
- `pc_in` in 12: instruction PC.
- `mem_rd_in` in 1: instruction loads from memory.
- `mem_wr_in` in 1: instruction stores to memory.
- `addr_in` in 12: effective address.
- `data_in` in 12: store data, or pass-through result for non-memory instructions.
- `stall_out` out 1: upstream must hold all inputs stable while 1.
- `mem_req` out 1: memory request, registered.
- `mem_we` out 1: 1 = write, 0 = read; valid while `mem_req`=1.
- `mem_addr` out 12: access address; valid while `mem_req`=1.
- `mem_wdata` out 12: write data; valid while `mem_req`=1.
- `mem_ack` in 1: single-cycle completion pulse from memory.
- `mem_rdata` in 12: read data; valid when `mem_ack`=1.
- `done_out` out 1: one-cycle pulse; outputs below valid; drives the MO/RA latch `enable`.
- `instr_out` out 12: completed instruction.
- `instr_set_out` out 4: completed instruction set.
- `pc_out` out 12: completed PC.
- `result_out` out 12: load data, or pass-through `data_in`.
- `bus_err_out` out 1: qualifies `done_out`; access aborted.

## Operation
- FSM states:
  - IDLE: accepting.
  - REQ: access outstanding.
- IDLE, `valid_in`=0: no capture; `done_out`=0 next cycle.
- IDLE, `valid_in`=1, no memory operation:
  - Capture `instr`, `set`, `pc` into the output registers; `result_out` <= `data_in`.
  - `done_out`=1 for the next cycle; state stays IDLE.
- IDLE, `valid_in`=1, `mem_rd_in` or `mem_wr_in` set:
  - Capture `instr`, `set`, `pc`, `addr`, `wdata`.
  - `mem_we` <= `mem_wr_in`; `mem_req` <= 1; state -> REQ.
- If both `mem_rd_in` and `mem_wr_in` are set, the access is a store and `result_out` is `data_in`.
- REQ: `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are held constant.
- REQ with `mem_ack` sampled 1:
  - `mem_req` <= 0; state -> IDLE; `done_out` <= 1.
  - `result_out` <= `mem_rdata` for a read; unchanged pass-through `data_in` captured at accept for a write.
- `stall_out` = (state == REQ), combinational.
- Upstream may present a new instruction in the cycle `done_out` is high; it is accepted because the state is already IDLE.
- `mem_ack` while IDLE is ignored.
- `rst` while in REQ drops `mem_req` at that edge; the access is abandoned and no `done_out` is produced.
- Reset values:
  - state = IDLE.
  - `mem_req`, `mem_we`, `done_out`, `bus_err_out` = 0.
  - `mem_addr`, `mem_wdata`, `instr_out`, `pc_out`, `result_out` = 12'h000.
  - `instr_set_out` = `ISET_BASE`.
  - Timeout counter = 0.

## Timing
- Non-memory instruction: latency 1; `done_out` in the cycle after acceptance; throughput 1 per cycle.
- Memory instruction with zero-wait memory:
  - Accept at edge E0; `mem_req`=1 in cycle 1.
  - `mem_ack`=1 in cycle 1, sampled at E1; `done_out`=1 in cycle 2.
  - Minimum latency 2; `stall_out`=1 during cycle 1 only.
- Each wait cycle of memory adds one cycle of latency and one cycle of `stall_out`.
- `done_out` is never high for two consecutive cycles for the same instruction.
- The output registers hold their values until the next completion.

## Configuration
- Macro `MO_TIMEOUT_EN`.
- Defined:
  - A 4-bit counter clears on entry to REQ and increments each REQ cycle without `mem_ack`.
  - When the counter equals `TIMEOUT_CYCLES` with no ack: `mem_req` <= 0, state -> IDLE, `done_out` <= 1, `bus_err_out` <= 1, `result_out` <= 12'h000.
  - `mem_ack` in the same cycle as the timeout wins: normal completion, no error.
- Undefined: REQ waits indefinitely; `bus_err_out` is constant 0; no counter is built.

## Test plan
- Reset, then ALU instruction: `valid_in`=1, `instr`=12'h123, `pc`=12'h010, `data_in`=12'hABC -> next cycle `done_out`=1, `result_out`=12'hABC, `pc_out`=12'h010, `stall_out`=0.
- Zero-wait load: `mem_rd_in`=1, `addr`=12'h040; memory acks in the first `mem_req` cycle with `rdata`=12'h5A5 -> `mem_req` high 1 cycle, `stall_out` high 1 cycle, `done_out` the following cycle, `result_out`=12'h5A5.
- Store with 3 wait cycles: `mem_wr_in`=1, `addr`=12'h7FF, `data_in`=12'h0F0 -> `mem_we`=1, `mem_wdata`=12'h0F0 stable for 4 cycles, `stall_out` 4 cycles, single `done_out`, `result_out`=12'h0F0.
- Back-to-back: ALU, load, ALU on consecutive cycles with zero-wait memory -> three `done_out` pulses, one bubble after the load.
- Reset asserted during REQ -> `mem_req`=0 after that edge, no `done_out`, `instr_set_out`=`ISET_BASE`.
- With `MO_TIMEOUT_EN`, `TIMEOUT_CYCLES`=15, no ack -> `done_out`=1 with `bus_err_out`=1 and `result_out`=12'h000.

Source files
------------

// File: rtl/stage_mo.sv
// -----------------------------------------------------------------------------
// stage_mo -- Memory Operation stage of the 12-bit core.
//
// Accepts one instruction per cycle from the upstream latch. It performs at most
// one data-memory access per instruction over a registered req/ack port. While
// that access is outstanding it stalls upstream. Each completed instruction is
// presented to the MO/RA latch, with done_out acting as that latch's enable.
//
// Optional feature macro: MO_TIMEOUT_EN
//   When defined, an access that waits TIMEOUT_CYCLES cycles without mem_ack is
//   aborted. It then completes with bus_err_out=1 and result_out=0.
//   When undefined, REQ waits indefinitely and bus_err_out is tied to 0.
//
// Parameters
//   TIMEOUT_CYCLES  wait-cycle limit before abort (1..15), MO_TIMEOUT_EN only
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   valid_in        upstream instruction valid (0 = bubble)
//   instr_in        instruction word
//   instr_set_in    active instruction set
//   pc_in           instruction PC
//   mem_rd_in       instruction loads from memory
//   mem_wr_in       instruction stores to memory (wins over mem_rd_in)
//   addr_in         effective address
//   data_in         store data, or pass-through result
//   stall_out       upstream must hold its inputs while 1
//   mem_req         registered memory request
//   mem_we          1 = write, 0 = read (valid with mem_req)
//   mem_addr        access address (valid with mem_req)
//   mem_wdata       write data (valid with mem_req)
//   mem_ack         single-cycle completion pulse from memory
//   mem_rdata       read data, valid with mem_ack
//   done_out        one-cycle completion pulse, enable for the MO/RA latch
//   instr_out       completed instruction
//   instr_set_out   completed instruction set
//   pc_out          completed PC
//   result_out      load data or pass-through data
//   bus_err_out     qualifies done_out: access was aborted
// -----------------------------------------------------------------------------
module stage_mo #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [11:0] instr_in,
  input  logic [3:0]  instr_set_in,
  input  logic [11:0] pc_in,
  input  logic        mem_rd_in,
  input  logic        mem_wr_in,
  input  logic [11:0] addr_in,
  input  logic [11:0] data_in,
  output logic        stall_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [11:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [11:0] mem_rdata,
  output logic        done_out,
  output logic [11:0] instr_out,
  output logic [3:0]  instr_set_out,
  output logic [11:0] pc_out,
  output logic [11:0] result_out,
  output logic        bus_err_out
);

  localparam logic [3:0] ISET_BASE = 4'h0;

  // Reject an out-of-range limit at elaboration. A 4-bit counter cannot
  // represent anything larger than 15.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 15) begin : g_bad_timeout
    $error("stage_mo: TIMEOUT_CYCLES must be in 1..15");
  end

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Single-cycle decisions taken by the next-state logic.
  logic accept_alu;   // non-memory instruction accepted, completes next cycle
  logic accept_mem;   // memory instruction accepted, request launched
  logic ack_done;     // outstanding access acknowledged

  // Instruction identity is parked here during REQ. This keeps the output
  // registers holding the previous completion until this one finishes.
  logic [11:0] pend_instr;
  logic [3:0]  pend_set;
  logic [11:0] pend_pc;

`ifdef MO_TIMEOUT_EN
  localparam logic [3:0] TMO_LIMIT = 4'(TIMEOUT_CYCLES);
  logic [3:0] tmo_cnt;
  logic       tmo_done;   // access abandoned with a bus error
`endif

  assign stall_out = (state == REQ);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    accept_alu = 1'b0;
    accept_mem = 1'b0;
    ack_done   = 1'b0;
`ifdef MO_TIMEOUT_EN
    tmo_done   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (valid_in) begin
          if (mem_rd_in || mem_wr_in) begin
            accept_mem = 1'b1;
            state_nxt  = REQ;
          end else begin
            accept_alu = 1'b1;
          end
        end
      end
      REQ: begin
        // An ack in the same cycle as the timeout takes priority.
        if (mem_ack) begin
          ack_done  = 1'b1;
          state_nxt = IDLE;
        end
`ifdef MO_TIMEOUT_EN
        else if (tmo_cnt == TMO_LIMIT) begin
          tmo_done  = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, memory port and MO/RA output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= 12'h000;
      mem_wdata     <= 12'h000;
      done_out      <= 1'b0;
      instr_out     <= 12'h000;
      instr_set_out <= ISET_BASE;
      pc_out        <= 12'h000;
      result_out    <= 12'h000;
`ifdef MO_TIMEOUT_EN
      bus_err_out   <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      done_out <= 1'b0;

      if (accept_alu) begin
        instr_out     <= instr_in;
        instr_set_out <= instr_set_in;
        pc_out        <= pc_in;
        result_out    <= data_in;
        done_out      <= 1'b1;
`ifdef MO_TIMEOUT_EN
        bus_err_out   <= 1'b0;
`endif
      end

      if (accept_mem) begin
        mem_req   <= 1'b1;
        mem_we    <= mem_wr_in;
        mem_addr  <= addr_in;
        // For a store, mem_wdata doubles as the pass-through result.
        mem_wdata <= data_in;
      end

      if (ack_done) begin
        mem_req       <= 1'b0;
        done_out      <= 1'b1;
        instr_out     <= pend_instr;
        instr_set_out <= pend_set;
        pc_out        <= pend_pc;
        result_out    <= mem_we ? mem_wdata : mem_rdata;
`ifdef MO_TIMEOUT_EN
        bus_err_out   <= 1'b0;
`endif
      end

`ifdef MO_TIMEOUT_EN
      if (tmo_done) begin
        mem_req       <= 1'b0;
        done_out      <= 1'b1;
        instr_out     <= pend_instr;
        instr_set_out <= pend_set;
        pc_out        <= pend_pc;
        result_out    <= 12'h000;
        bus_err_out   <= 1'b1;
      end
`endif
    end
  end

  // NOTE: pend_* are pure datapath holding registers. They are written at
  // every memory accept before they are ever read, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept_mem) begin
      pend_instr <= instr_in;
      pend_set   <= instr_set_in;
      pend_pc    <= pc_in;
    end
  end

`ifdef MO_TIMEOUT_EN
  // The counter holds the number of unacknowledged REQ cycles seen so far.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= 4'd0;
    end else if (accept_mem) begin
      tmo_cnt <= 4'd0;
    end else if (state == REQ && !mem_ack && !tmo_done) begin
      tmo_cnt <= tmo_cnt + 4'd1;
    end
  end
`else
  assign bus_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_stage_mo.sv
module tb_stage_mo;

  localparam int         TMO       = 15;
  localparam logic [3:0] ISET_BASE = 4'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [11:0] instr_in;
  logic [3:0]  instr_set_in;
  logic [11:0] pc_in;
  logic        mem_rd_in;
  logic        mem_wr_in;
  logic [11:0] addr_in;
  logic [11:0] data_in;
  logic        stall_out;
  logic        mem_req;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [11:0] mem_wdata;
  logic        mem_ack;
  logic [11:0] mem_rdata;
  logic        done_out;
  logic [11:0] instr_out;
  logic [3:0]  instr_set_out;
  logic [11:0] pc_out;
  logic [11:0] result_out;
  logic        bus_err_out;

  always #5 clk = ~clk;

  stage_mo #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .instr_in(instr_in),
    .instr_set_in(instr_set_in), .pc_in(pc_in), .mem_rd_in(mem_rd_in),
    .mem_wr_in(mem_wr_in), .addr_in(addr_in), .data_in(data_in),
    .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .done_out(done_out), .instr_out(instr_out),
    .instr_set_out(instr_set_out), .pc_out(pc_out), .result_out(result_out),
    .bus_err_out(bus_err_out)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level reference model. It is updated on each rising edge from
  // the inputs that were applied before it.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [11:0] instr;
    logic [3:0]  set;
    logic [11:0] pc;
    logic [11:0] result;
    logic        err;
  } txn_t;

  txn_t        m_out;          // what the MO/RA outputs must show
  txn_t        m_pend;         // memory instruction in flight
  logic        m_busy = 1'b0;  // an access is outstanding
  logic        m_pend_wr;
  logic [11:0] m_addr;
  logic        m_done = 1'b0;
  int          m_wait;         // unacknowledged cycles of the current access

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      m_out  = '{12'h000, ISET_BASE, 12'h000, 12'h000, 1'b0};
    end else if (!m_busy) begin
      if (valid_in && (mem_rd_in || mem_wr_in)) begin
        m_busy    = 1'b1;
        m_pend    = '{instr_in, instr_set_in, pc_in, data_in, 1'b0};
        m_pend_wr = mem_wr_in;
        m_addr    = addr_in;
        m_wait    = 0;
      end else if (valid_in) begin
        m_out  = '{instr_in, instr_set_in, pc_in, data_in, 1'b0};
        m_done = 1'b1;
      end
    end else if (mem_ack) begin
      m_out = m_pend;
      if (!m_pend_wr) m_out.result = mem_rdata;
      m_busy = 1'b0;
      m_done = 1'b1;
    end else begin
`ifdef MO_TIMEOUT_EN
      if (m_wait == TMO) begin
        m_out        = m_pend;
        m_out.result = 12'h000;
        m_out.err    = 1'b1;
        m_busy       = 1'b0;
        m_done       = 1'b1;
      end else begin
        m_wait++;
      end
`else
      m_wait++;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Single compare process: every falling edge, DUT against model.
  // ---------------------------------------------------------------------------
  logic cmp_en    = 1'b0;
  int   done_seen = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      if (done_out) done_seen++;
      check("stall", stall_out, m_busy);
      check("mem_req", mem_req, m_busy);
      check("done", done_out, m_done);
      if (m_busy) begin
        check("mem_we", mem_we, m_pend_wr);
        check("mem_addr", mem_addr, m_addr);
        check("mem_wdata", mem_wdata, m_pend.result);
      end
      check("instr_out", instr_out, m_out.instr);
      check("set_out", instr_set_out, m_out.set);
      check("pc_out", pc_out, m_out.pc);
      check("result_out", result_out, m_out.result);
      check("bus_err", bus_err_out, m_out.err);
    end
  end

  // ---------------------------------------------------------------------------
  // Memory responder: acks after ack_wait wait cycles. In random mode it also
  // sends stray acks while idle, which the DUT must ignore.
  // ---------------------------------------------------------------------------
  logic        rand_mode = 1'b0;
  int          ack_wait  = 0;
  int          req_age   = 0;
  logic [11:0] rd_val    = 12'h000;

  always @(posedge clk) begin
    #2;
    if (mem_req) begin
      mem_ack   = (req_age == ack_wait);
      mem_rdata = mem_ack ? rd_val : 12'($urandom);
      req_age++;
    end else begin
      req_age   = 0;
      mem_ack   = rand_mode && ($urandom_range(0, 7) == 0);
      mem_rdata = 12'($urandom);
      if (rand_mode) begin
        ack_wait = $urandom_range(0, 4);
        rd_val   = 12'($urandom);
      end
    end
  end

  // Inputs change 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [11:0] ins,
                       input logic [3:0] st, input logic [11:0] pc, input logic [11:0] ad,
                       input logic [11:0] dt);
    valid_in = v; mem_rd_in = rd; mem_wr_in = wr; instr_in = ins;
    instr_set_in = st; pc_in = pc; addr_in = ad; data_in = dt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 12'h000, 4'h0, 12'h000, 12'h000, 12'h000);
  endtask

  int base;
  logic got;

  initial begin
    rst = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = 12'h000;
    idle();
    step();
    cmp_en = 1'b1;
    step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_done", done_out, 1'b0);
    check("rst_stall", stall_out, 1'b0);
    check("rst_set", instr_set_out, ISET_BASE);
    check("rst_result", result_out, 12'h000);

    // ALU instruction, latency 1
    step();
    drive(1'b1, 1'b0, 1'b0, 12'h123, 4'h5, 12'h010, 12'h000, 12'hABC);
    step();
    idle();
    @(negedge clk);
    check("alu_done", done_out, 1'b1);
    check("alu_result", result_out, 12'hABC);
    check("alu_pc", pc_out, 12'h010);
    check("alu_instr", instr_out, 12'h123);
    check("alu_stall", stall_out, 1'b0);

    // Zero-wait load
    step();
    ack_wait = 0;
    rd_val = 12'h5A5;
    drive(1'b1, 1'b1, 1'b0, 12'h456, 4'h2, 12'h011, 12'h040, 12'h333);
    step();
    @(negedge clk);
    check("ld_req", mem_req, 1'b1);
    check("ld_stall", stall_out, 1'b1);
    check("ld_addr", mem_addr, 12'h040);
    check("ld_we", mem_we, 1'b0);
    check("ld_hold_result", result_out, 12'hABC);
    step();
    idle();
    @(negedge clk);
    check("ld_done", done_out, 1'b1);
    check("ld_result", result_out, 12'h5A5);
    check("ld_req_drop", mem_req, 1'b0);
    check("ld_stall_drop", stall_out, 1'b0);

    // Store with 3 wait cycles
    step();
    ack_wait = 3;
    drive(1'b1, 1'b0, 1'b1, 12'h789, 4'h3, 12'h012, 12'h7FF, 12'h0F0);
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("st_req", mem_req, 1'b1);
      check("st_we", mem_we, 1'b1);
      check("st_wdata", mem_wdata, 12'h0F0);
      check("st_stall", stall_out, 1'b1);
      check("st_no_done", done_out, 1'b0);
      step();
    end
    idle();
    @(negedge clk);
    check("st_done", done_out, 1'b1);
    check("st_result", result_out, 12'h0F0);
    step();
    @(negedge clk);
    check("st_single_done", done_out, 1'b0);

    // Back-to-back ALU, load, ALU with zero-wait memory
    ack_wait = 0;
    rd_val = 12'h246;
    base = done_seen;
    drive(1'b1, 1'b0, 1'b0, 12'h101, 4'h1, 12'h020, 12'h000, 12'h111);
    step();
    drive(1'b1, 1'b1, 1'b0, 12'h102, 4'h1, 12'h021, 12'h055, 12'h222);
    step();
    step();  // load held while stalled
    drive(1'b1, 1'b0, 1'b0, 12'h103, 4'h1, 12'h022, 12'h000, 12'h333);
    step();
    idle();
    repeat (3) step();
    @(negedge clk);
    check("b2b_done_count", done_seen - base, 3);
    check("b2b_last_result", result_out, 12'h333);

    // Reset while in REQ
    ack_wait = 99;
    drive(1'b1, 1'b1, 1'b0, 12'h0AA, 4'h7, 12'h030, 12'h066, 12'h000);
    step();
    @(negedge clk);
    check("rreq_req", mem_req, 1'b1);
    step();
    rst = 1'b1;
    idle();
    base = done_seen;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rreq_req_drop", mem_req, 1'b0);
    check("rreq_set", instr_set_out, ISET_BASE);
    repeat (4) step();
    @(negedge clk);
    check("rreq_no_done", done_seen - base, 0);
    ack_wait = 0;

`ifdef MO_TIMEOUT_EN
    // No ack at all: the access must time out with a bus error.
    ack_wait = 99;
    drive(1'b1, 1'b1, 1'b0, 12'h0BB, 4'h4, 12'h040, 12'h077, 12'h999);
    step();
    idle();
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done_out) got = 1'b1;
      else step();
    end
    check("tmo_done_seen", got, 1'b1);
    check("tmo_bus_err", bus_err_out, 1'b1);
    check("tmo_result", result_out, 12'h000);
    step();
    ack_wait = 0;
`endif

    // Randomised traffic with random waits, stray acks and resets.
    rand_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 63) == 0) rst = 1'b1;
      if (!m_busy) begin
        case ($urandom_range(0, 3))
          0: drive(1'b1, 1'b0, 1'b0, 12'($urandom), 4'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
          1: drive(1'b1, 1'b1, 1'b0, 12'($urandom), 4'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
          2: drive(1'b1, 1'b0, 1'b1, 12'($urandom), 4'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
          default: drive(1'b1, 1'b1, 1'b1, 12'($urandom), 4'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
        endcase
        if ($urandom_range(0, 3) == 0) valid_in = 1'b0;
      end
    end
    step();
    idle();
    rst = 1'b0;
    repeat (3) step();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
